uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  Bus-attached UART transmitter: the counterpart that drives the serial line our uart_rx samples.
//  CPU writes bytes into an internal TX FIFO; a baud-timed FSM serialises them as 8N1, LSB first.
//  Same bus slave style as uart_rx: 1-bit address (0 = data, 1 = status); o_int flags "all sent".
// PARAMETERS
//  SYS_CLK    25_000_000  system clock in Hz
//  BAUDRATE   115200      line rate; TICK = SYS_CLK/BAUDRATE clocks per bit (217 by default)
//  DEPTH      8           TX FIFO entries, power of two >= 2, held inside this module
// PORTS
//  i_clk     in   1  system clock, all logic on rising edge
//  i_reset   in   1  synchronous, active-high reset
//  i_dat     in   8  write data (byte to send)
//  o_dat     out  8  read data: addr 1 = {5'd0, overflow, busy, full}; addr 0 = 8'd0
//  i_addr    in   1  register select, 0 = data, 1 = status
//  i_we      in   1  1 = write, 0 = read; qualified by i_cyc
//  i_cyc     in   1  bus cycle active; each cycle with i_cyc=1 is one access
//  tx        out  1  serial output, idles high
//  o_int     out  1  1-clock pulse when last queued byte's stop bit completes
// BEHAVIOUR
//  Reset: tx=1, o_int=0, FIFO empty, overflow=0, FSM IDLE, baud counter 0; a frame in flight is aborted,
//   tx high from the edge after reset is sampled; aborted byte and queued bytes are discarded.
//  Push: i_cyc & i_we & i_addr==0 pushes i_dat. If FIFO full (count before this edge == DEPTH) the
//   write is dropped and overflow<=1, even if the FSM pops in the same cycle.
//  Status read: i_cyc & ~i_we & i_addr==1; o_dat is combinational on i_addr. A status read clears
//   overflow at that edge (set wins if overflow-setting write coincides -- impossible, same bus cycle).
//  full = (count==DEPTH); busy = (state!=IDLE) | ~empty. Writes at addr 1 and reads at addr 0 ignored.
//  FSM states: IDLE, START, DATA, STOP. Baud counter resets to 0 on every state entry, bit ends when
//   counter == TICK-1, so every line bit is exactly TICK clocks.
//   IDLE : tx=1. If FIFO non-empty: pop head into shift reg, go START.
//   START: tx=0 for TICK clocks -> DATA, bit index 0.
//   DATA : tx=shift[idx], idx 0..7 (LSB first); after bit 7 -> STOP.
//   STOP : tx=1 for TICK clocks. Then if FIFO non-empty: pop, go START directly (no idle gap);
//          else go IDLE and pulse o_int for exactly one clock.
//  Latency: write sampled at edge E into empty FIFO with FSM IDLE -> pop at E+1 -> tx low from E+2.
//  Push and pop in same cycle: both take effect, count unchanged (unless full-drop rule applies).
//  FIFO pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
//  tx is registered (no glitches); o_dat is the only combinational output.
// TESTING (SYS_CLK=25M, BAUDRATE=115200, TICK=217, DEPTH=8)
//  Write 0x55 at edge E -> tx low E+2..E+218, then 1,0,1,0,1,0,1,0 each 217 clk, stop high 217 clk;
//   o_int high one clock at frame end; status read then returns 0x00.
//  Write 0x01,0x02,0x03 on consecutive cycles -> three contiguous frames (6510 clk total, no gap),
//   bytes decode as 0x01,0x02,0x03, exactly one o_int pulse after the third stop bit.
//  10 writes on consecutive cycles -> first popped to FSM, next 8 fill FIFO, status reads 0x03 after
//   9th write, 10th dropped; status read = 0x07, next status read = 0x03; exactly 9 frames sent.
//  During any frame status bit1=1; after final o_int status = 0x00 and tx stays 1 indefinitely.
//  Assert i_reset mid DATA bit 3 with 4 bytes queued -> tx=1 next edge, status 0x00, no o_int,
//   no further frames; a new write afterwards transmits normally with correct timing.
//  Loopback tx into uart_rx (same parameters), send 0x00,0xFF,0xA5 -> uart_rx FIFO yields same bytes.

Source files
------------

// File: rtl/uart_tx.sv
// Bus-attached 8N1 UART transmitter with an internal TX FIFO and an "all sent" interrupt pulse.
// The serial line is registered one clock behind the FSM, so every line bit lasts exactly TICK clocks.
module uart_tx #(
    parameter int SYS_CLK  = 25_000_000,
    parameter int BAUDRATE = 115200,
    parameter int DEPTH    = 8
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_dat,
    output logic [7:0] o_dat,
    input  logic       i_addr,
    input  logic       i_we,
    input  logic       i_cyc,
    output logic       tx,
    output logic       o_int
);

    localparam int TICK = SYS_CLK / BAUDRATE;
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = $clog2(TICK);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;

    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            overflow;

    logic            push_req;
    logic            push;
    logic            pop;
    logic            stat_rd;
    logic            full;
    logic            empty;
    logic            busy;
    logic            bit_done;
    logic            line;

    assign push_req = i_cyc & i_we & ~i_addr;
    assign stat_rd  = i_cyc & ~i_we & i_addr;
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign push     = push_req & ~full;
    assign bit_done = (baud_cnt == TICK_LAST);
    assign busy     = (state != IDLE) | ~empty;

    // The FSM takes the FIFO head when idle, or back-to-back at the end of a stop bit.
    assign pop = ~empty & ((state == IDLE) | ((state == STOP) & bit_done));

    always_comb begin
        line = 1'b1;
        case (state)
            START:   line = 1'b0;
            DATA:    line = shift[bit_idx];
            default: line = 1'b1;
        endcase
    end

    assign o_dat = i_addr ? {5'd0, overflow, busy, full} : 8'd0;

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_dat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A dropped write is judged on the count before this edge, even if a pop coincides.
            if (push_req & full) begin
                overflow <= 1'b1;
            end else if (stat_rd) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= 1'b1;
            o_int    <= 1'b0;
        end else begin
            o_int <= 1'b0;
            tx    <= line;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        state <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            state <= START;
                        end else begin
                            state <= IDLE;
                            o_int <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    baud_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: exact bit timing, back-to-back frames, FIFO overflow,
// mid-frame reset and a mid-bit serial decoder standing in for the receiver.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int TICK  = 217;
    localparam int FRAME = 10 * TICK;

    logic       clk;
    logic       rst;
    logic [7:0] wdat;
    logic [7:0] rdat;
    logic       addr;
    logic       we;
    logic       cyc;
    logic       line;
    logic       irq;

    int n_vec;
    int n_err;
    int ncyc;
    int int_cnt;
    logic [7:0] exp_q [$];

    uart_tx #(.SYS_CLK(25_000_000), .BAUDRATE(115200), .DEPTH(8)) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .i_dat  (wdat),
        .o_dat  (rdat),
        .i_addr (addr),
        .i_we   (we),
        .i_cyc  (cyc),
        .tx     (line),
        .o_int  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (irq === 1'b1) int_cnt++;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        ncyc++;
        #1;
    endtask

    task automatic run_to(input int target);
        if (ncyc > target) chk("schedule_late", ncyc, target);
        while (ncyc < target) tick();
    endtask

    task automatic write_byte(input logic [7:0] d);
        cyc = 1'b1; we = 1'b1; addr = 1'b0; wdat = d;
        tick();
        cyc = 1'b0; we = 1'b0;
    endtask

    task automatic read_status(output logic [7:0] v);
        cyc = 1'b1; we = 1'b0; addr = 1'b1;
        #1;
        v = rdat;
        tick();
        cyc = 1'b0; addr = 1'b0;
    endtask

    // Samples each line bit at its centre, frames assumed to start at s and abut each other.
    task automatic decode(input string tag, input int s, input int nfr);
        logic [7:0] b;
        for (int j = 0; j < nfr; j++) begin
            b = 8'h00;
            for (int k = 0; k < 10; k++) begin
                run_to(s + FRAME * j + TICK * k + TICK / 2);
                if (k == 0) chk({tag, "_start"}, line, 1'b0);
                else if (k == 9) chk({tag, "_stop"}, line, 1'b1);
                else b[k-1] = line;
            end
            chk({tag, "_byte"}, b, exp_q[j]);
        end
    endtask

    task automatic idle_check(input string tag, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (line !== 1'b1) bad++;
        end
        chk(tag, bad, 0);
    endtask

    initial begin
        logic [7:0] st;
        logic [7:0] pat;
        int e;
        int s;
        int ic;

        n_vec = 0; n_err = 0; ncyc = 0; int_cnt = 0;
        rst = 1'b1; wdat = 8'h00; addr = 1'b0; we = 1'b0; cyc = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;
        chk("reset_tx", line, 1'b1);
        chk("reset_int", irq, 1'b0);
        read_status(st);
        chk("reset_status", st, 8'h00);
        addr = 1'b0; #1;
        chk("data_read_zero", rdat, 8'h00);

        // Single byte 0x55: every bit edge checked against the write edge.
        pat = 8'h55;
        ic = int_cnt;
        write_byte(pat);
        e = ncyc;
        chk("t1_tx_at_E", line, 1'b1);
        run_to(e + 1);
        chk("t1_tx_at_E1", line, 1'b1);
        run_to(e + 2);
        chk("t1_tx_at_E2", line, 1'b0);
        read_status(st);
        chk("t1_busy_status", st, 8'h02);
        for (int b = 0; b < 9; b++) begin
            if (b > 0) begin
                run_to(e + 2 + TICK * b);
                chk("t1_bit_first", line, pat[b-1]);
            end
            run_to(e + 2 + TICK * b + TICK - 1);
            chk("t1_bit_last", line, (b == 0) ? 1'b0 : pat[b-1]);
        end
        run_to(e + 2 + TICK * 9);
        chk("t1_stop_first", line, 1'b1);
        run_to(e + 2170);
        chk("t1_int_before", irq, 1'b0);
        run_to(e + 2171);
        chk("t1_int_pulse", irq, 1'b1);
        chk("t1_stop_last", line, 1'b1);
        run_to(e + 2172);
        chk("t1_int_after", irq, 1'b0);
        chk("t1_int_count", int_cnt - ic, 1);
        read_status(st);
        chk("t1_final_status", st, 8'h00);

        // Three bytes back to back.
        ic = int_cnt;
        exp_q = '{8'h01, 8'h02, 8'h03};
        write_byte(8'h01);
        e = ncyc;
        write_byte(8'h02);
        write_byte(8'h03);
        s = e + 2;
        decode("t2", s, 3);
        run_to(s + 3 * FRAME + 2);
        chk("t2_int_count", int_cnt - ic, 1);
        idle_check("t2_idle", 300);
        read_status(st);
        chk("t2_final_status", st, 8'h00);

        // Ten writes: one to the FSM, eight fill the FIFO, the last is dropped.
        ic = int_cnt;
        exp_q.delete();
        for (int i = 0; i < 9; i++) begin
            write_byte(8'h10 + 8'(i));
            if (i == 0) e = ncyc;
            exp_q.push_back(8'h10 + 8'(i));
        end
        read_status(st);
        chk("t3_full_status", st, 8'h03);
        write_byte(8'h19);
        read_status(st);
        chk("t3_overflow_status", st, 8'h07);
        read_status(st);
        chk("t3_overflow_cleared", st, 8'h03);
        s = e + 2;
        decode("t3", s, 9);
        run_to(s + 9 * FRAME + 2);
        chk("t3_int_count", int_cnt - ic, 1);
        idle_check("t3_no_tenth_frame", 2400);
        read_status(st);
        chk("t3_final_status", st, 8'h00);

        // Reset in the middle of data bit 3 with bytes still queued.
        ic = int_cnt;
        write_byte(8'hC3);
        e = ncyc;
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        s = e + 2;
        run_to(s + TICK * 4 + 99);
        chk("t4_tx_bit3_low", line, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_tx_after_reset", line, 1'b1);
        read_status(st);
        chk("t4_status_after_reset", st, 8'h00);
        idle_check("t4_no_frames", 2500);
        chk("t4_no_int", int_cnt - ic, 0);
        exp_q = '{8'hA5};
        write_byte(8'hA5);
        e = ncyc;
        run_to(e + 1);
        chk("t4_new_tx_E1", line, 1'b1);
        run_to(e + 2);
        chk("t4_new_tx_E2", line, 1'b0);
        decode("t4", e + 2, 1);
        run_to(e + 2172);
        chk("t4_int_count", int_cnt - ic, 1);

        // Boundary byte values decoded as a receiver would see them.
        ic = int_cnt;
        exp_q = '{8'h00, 8'hFF, 8'hA5};
        write_byte(8'h00);
        e = ncyc;
        write_byte(8'hFF);
        write_byte(8'hA5);
        decode("t5", e + 2, 3);
        run_to(e + 2 + 3 * FRAME + 2);
        chk("t5_int_count", int_cnt - ic, 1);
        read_status(st);
        chk("t5_final_status", st, 8'h00);
        idle_check("t5_idle", 300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
